// File: rtl/multi_n_arb.sv
// multi_n_arb: N-channel registered mux with valid/ready on every port.
// Channel chosen by external select (MODE=0) or round-robin (MODE=1).
module multi_n_arb #(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = 0,
    parameter int SW   = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   S,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   grant
);

    logic          free;
    logic          cand_ok;
    logic [SW-1:0] cand;
    logic          rr_ok;
    logic [SW-1:0] rr_idx;
    logic          sel_valid;
    logic [W-1:0]  sel_data;
    logic          accept;

    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    // Output slot can take a word; held low while reset is asserted
    assign free = reset_n && (!valid_q || out_ready);

    // Round-robin search starting one past the last granted channel
    always_comb begin
        int j;
        j      = 0;
        rr_ok  = 1'b0;
        rr_idx = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!rr_ok && in_valid[j]) begin
                rr_ok  = 1'b1;
                rr_idx = SW'(j);
            end
        end
    end

    // Candidate channel: external select or arbiter winner
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (MODE == 1) begin
            cand    = rr_idx;
            cand_ok = rr_ok;
        end else begin
            cand    = S;
            cand_ok = (int'(S) < N);
        end
    end

    // Pick the candidate's word and valid bit
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(cand) == i) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[i*W +: W];
            end
        end
    end

    // One-hot ready toward the candidate whenever the slot is free
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = free && cand_ok && (int'(cand) == i);
        end
    end

    assign accept = free && cand_ok && sel_valid;

    // Load on accept, otherwise drain or hold
    always_comb begin
        data_d  = data_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (accept) begin
            data_d  = sel_data;
            grant_d = cand;
            valid_d = 1'b1;
            if (MODE == 1) begin
                ptr_d = cand;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register and arbiter pointer; pointer resets so channel 0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SW'(N - 1);
        end else begin
            data_q  <= data_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign grant     = grant_q;

endmodule
